// File: rtl/countdown_timer.sv
// M:SS BCD countdown timer: loads three clamped BCD digits, counts down once per tick while enabled.
// Optional macro COUNTDOWN_EXT_TICK_EN replaces the internal prescaler with an external tick_in pulse.
module countdown_timer #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned DIV_W    = 27
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       loadn,
    input  logic       enablen,
`ifdef COUNTDOWN_EXT_TICK_EN
    input  logic       tick_in,
`endif
    input  logic [3:0] units_of_seconds,
    input  logic [3:0] tens_of_seconds,
    input  logic [3:0] units_of_minutes,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       zero,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, PAUSED, RUN} state_t;

    state_t     state, state_nxt;
    logic [3:0] s1_q, s10_q, m1_q;
    logic [3:0] s1_n, s10_n, m1_n;
    logic [3:0] s1_dec, s10_dec, m1_dec;
    logic [3:0] ld_s1, ld_s10, ld_m1;
    logic       done_q, done_n;
    logic       zero_q, running_q;
    logic       tick;
    logic       last_second;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

`ifdef COUNTDOWN_EXT_TICK_EN
    assign tick = (state == RUN) && tick_in;
`else
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_n;

    // Divider only advances while actually running; any pause or load discards the partial second.
    always_comb begin
        div_n = div_q;
        if (!loadn || state != RUN || enablen)
            div_n = '0;
        else if (div_q == DIV_MAX)
            div_n = '0;
        else
            div_n = div_q + 1'b1;
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn)
            div_q <= '0;
        else
            div_q <= div_n;
    end

    assign tick = (state == RUN) && (div_q == DIV_MAX);
`endif

    assign ld_s1  = clamp_bcd(units_of_seconds, 4'd9);
    assign ld_s10 = clamp_bcd(tens_of_seconds, 4'd5);
    assign ld_m1  = clamp_bcd(units_of_minutes, 4'd9);

    assign last_second = (m1_q == 4'd0) && (s10_q == 4'd0) && (s1_q == 4'd1);

    // BCD decrement with borrow chain units -> tens -> minutes.
    always_comb begin
        s1_dec  = s1_q;
        s10_dec = s10_q;
        m1_dec  = m1_q;
        if (s1_q != 4'd0) begin
            s1_dec = s1_q - 4'd1;
        end else begin
            s1_dec = 4'd9;
            if (s10_q != 4'd0) begin
                s10_dec = s10_q - 4'd1;
            end else begin
                s10_dec = 4'd5;
                m1_dec  = m1_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        s1_n      = s1_q;
        s10_n     = s10_q;
        m1_n      = m1_q;
        done_n    = 1'b0;
        if (!loadn) begin
            s1_n      = ld_s1;
            s10_n     = ld_s10;
            m1_n      = ld_m1;
            state_nxt = (ld_s1 == 4'd0 && ld_s10 == 4'd0 && ld_m1 == 4'd0) ? IDLE : PAUSED;
        end else begin
            unique case (state)
                IDLE: state_nxt = IDLE;
                PAUSED: begin
                    if (!enablen)
                        state_nxt = RUN;
                end
                RUN: begin
                    if (enablen) begin
                        state_nxt = PAUSED;
                    end else if (tick && !zero_q) begin
                        s1_n  = s1_dec;
                        s10_n = s10_dec;
                        m1_n  = m1_dec;
                        if (last_second) begin
                            state_nxt = IDLE;
                            done_n    = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state     <= IDLE;
            s1_q      <= '0;
            s10_q     <= '0;
            m1_q      <= '0;
            done_q    <= 1'b0;
            zero_q    <= 1'b1;
            running_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            s1_q      <= s1_n;
            s10_q     <= s10_n;
            m1_q      <= m1_n;
            done_q    <= done_n;
            zero_q    <= (s1_n == 4'd0) && (s10_n == 4'd0) && (m1_n == 4'd0);
            running_q <= (state_nxt == RUN);
        end
    end

    assign sec_ones = s1_q;
    assign sec_tens = s10_q;
    assign min_ones = m1_q;
    assign zero     = zero_q;
    assign running  = running_q;
    assign done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (default build, internal prescaler with TICK_DIV=4).
module tb_countdown_timer;

    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       clearn;
    logic       loadn;
    logic       enablen;
    logic [3:0] units_of_seconds, tens_of_seconds, units_of_minutes;
    logic [3:0] sec_ones, sec_tens, min_ones;
    logic       zero, running, done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: total remaining seconds, running flag, clocks since run entry/last tick.
    int secs;
    bit m_run;
    int phase;
    bit m_done;

    countdown_timer #(.TICK_DIV(TDIV), .DIV_W(2)) dut (
        .clk(clk),
        .clearn(clearn),
        .loadn(loadn),
        .enablen(enablen),
        .units_of_seconds(units_of_seconds),
        .tens_of_seconds(tens_of_seconds),
        .units_of_minutes(units_of_minutes),
        .sec_ones(sec_ones),
        .sec_tens(sec_tens),
        .min_ones(min_ones),
        .zero(zero),
        .running(running),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int d, input int lim);
        return (d > lim) ? lim : d;
    endfunction

    task automatic model_reset();
        secs = 0; m_run = 0; phase = 0; m_done = 0;
    endtask

    task automatic model_step(input logic ld, input logic en, input int m, input int t, input int u);
        m_done = 0;
        if (!ld) begin
            secs  = clampi(m, 9) * 60 + clampi(t, 5) * 10 + clampi(u, 9);
            m_run = 0;
            phase = 0;
        end else if (m_run) begin
            if (en) begin
                m_run = 0;
                phase = 0;
            end else begin
                phase++;
                if (phase == TDIV) begin
                    phase = 0;
                    if (secs > 0) secs--;
                    if (secs == 0) begin
                        m_run  = 0;
                        m_done = 1;
                    end
                end
            end
        end else if (secs != 0 && !en) begin
            m_run = 1;
            phase = 0;
        end
    endtask

    task automatic compare_model();
        chk("min_ones", int'(min_ones), secs / 60);
        chk("sec_tens", int'(sec_tens), (secs % 60) / 10);
        chk("sec_ones", int'(sec_ones), secs % 10);
        chk("zero", int'(zero), int'(secs == 0));
        chk("running", int'(running), int'(m_run));
        chk("done", int'(done), int'(m_done));
    endtask

    task automatic cyc(input logic ld, input logic en, input int m, input int t, input int u);
        loadn            = ld;
        enablen          = en;
        units_of_minutes = 4'(m);
        tens_of_seconds  = 4'(t);
        units_of_seconds = 4'(u);
        @(posedge clk);
        model_step(ld, en, m, t, u);
        @(negedge clk);
        compare_model();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0, 0);
    endtask

    // Called at a negedge: asynchronous clear, checked before any clock edge.
    task automatic do_reset();
        clearn = 1'b0;
        #1;
        model_reset();
        compare_model();
        chk("rst_done_lit", int'(done), 0);
        chk("rst_zero_lit", int'(zero), 1);
        @(negedge clk);
        clearn = 1'b1;
    endtask

    initial begin
        int dones;
        bit saw059;
        clearn = 1'b0; loadn = 1'b1; enablen = 1'b1;
        units_of_seconds = '0; tens_of_seconds = '0; units_of_minutes = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        clearn = 1'b1;
        #1;
        compare_model();
        chk("reset_digits_lit", int'({min_ones, sec_tens, sec_ones}), 0);
        chk("reset_zero_lit", int'(zero), 1);
        chk("reset_running_lit", int'(running), 0);
        @(negedge clk);
        run_cycles(3);
        chk("idle_ignores_en_lit", int'(running), 0);

        // Load 1:05, count through both borrows to 0:00.
        cyc(1'b0, 1'b1, 1, 0, 5);
        cyc(1'b1, 1'b0, 0, 0, 0);
        chk("run_entry_lit", int'(running), 1);
        run_cycles(3);
        chk("pre_tick_lit", int'(sec_ones), 5);
        run_cycles(1);
        chk("first_tick_lit", int'(sec_ones), 4);
        dones = 0; saw059 = 0;
        for (int i = 0; i < 300; i++) begin
            run_cycles(1);
            if (done) dones++;
            if (min_ones == 4'd0 && sec_tens == 4'd5 && sec_ones == 4'd9) saw059 = 1;
        end
        chk("done_once_lit", dones, 1);
        chk("saw_0_59_lit", int'(saw059), 1);
        chk("end_zero_lit", int'(zero), 1);
        chk("end_running_lit", int'(running), 0);

        // 0:01 -> done after exactly TDIV clocks, then no underflow.
        cyc(1'b0, 1'b1, 0, 0, 1);
        cyc(1'b1, 1'b0, 0, 0, 0);
        run_cycles(TDIV - 1);
        chk("one_sec_nodone_lit", int'(done), 0);
        run_cycles(1);
        chk("one_sec_done_lit", int'(done), 1);
        run_cycles(10 * TDIV);
        chk("no_underflow_lit", int'({min_ones, sec_tens, sec_ones}), 0);

        // Clamp 15/7/12 -> 9:59.
        cyc(1'b0, 1'b1, 15, 7, 12);
        chk("clamp_lit", int'({min_ones, sec_tens, sec_ones}), 'h959);

        // Pause at prescaler=2 discards the partial second.
        cyc(1'b1, 1'b0, 0, 0, 0);
        run_cycles(2);
        cyc(1'b1, 1'b1, 0, 0, 0);
        chk("pause_running_lit", int'(running), 0);
        cyc(1'b1, 1'b1, 0, 0, 0);
        cyc(1'b1, 1'b0, 0, 0, 0);
        run_cycles(TDIV - 1);
        chk("pause_held_lit", int'({min_ones, sec_tens, sec_ones}), 'h959);
        run_cycles(1);
        chk("resume_tick_lit", int'({min_ones, sec_tens, sec_ones}), 'h958);

        // Load on the same clock as a tick wins.
        run_cycles(TDIV - 1);
        cyc(1'b0, 1'b0, 2, 3, 0);
        chk("load_vs_tick_lit", int'({min_ones, sec_tens, sec_ones}), 'h230);
        chk("load_vs_tick_run_lit", int'(running), 0);

        // Reset mid-run.
        cyc(1'b1, 1'b0, 0, 0, 0);
        run_cycles(TDIV + 1);
        chk("before_clear_lit", int'({min_ones, sec_tens, sec_ones}), 'h229);
        do_reset();
        run_cycles(2);

        // Randomised traffic against the model.
        enablen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic ld, en;
            int m, t, u;
            ld = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
            en = ($urandom_range(0, 15) == 0) ? ~enablen : enablen;
            m  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0;
            t  = int'($urandom_range(0, 7));
            u  = int'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cyc(ld, en, m, t, u);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Consumer end of the timer-entry interface: captures the three BCD digits (units of minutes, tens of seconds, units of seconds) when loadn is asserted.
- Counts them down M:SS once per second while enabled.
- Reports zero/done to the microwave controller and drives the display digits.
- Sits between the timer input/control block and the controller/7-segment decoders.

Parameters:
- TICK_DIV, 100000000, clk cycles per one-second tick (prescaler modulus, >=2).
- DIV_W, 27, prescaler counter width; must hold TICK_DIV-1.

Ports:
- clk  input  1  system clock
- clearn  input  1  asynchronous active-low reset
- loadn  input  1  active-low load strobe; level-sensitive, sampled each clk
- enablen  input  1  active-low count enable (0 = counting allowed)
- units_of_seconds  input  4  BCD load digit, seconds units
- tens_of_seconds  input  4  BCD load digit, seconds tens
- units_of_minutes  input  4  BCD load digit, minutes
- sec_ones  output  4  current seconds units (BCD)
- sec_tens  output  4  current seconds tens (BCD)
- min_ones  output  4  current minutes (BCD)
- zero  output  1  high when count is 0:00
- running  output  1  high in RUN state
- done  output  1  one-clk pulse when the count reaches 0:00 by decrement

Behaviour:
- Reset (clearn=0, async): digits 0/0/0, prescaler 0, state IDLE, zero=1, running=0, done=0.
- Load (loadn=0 at posedge): digits registered next edge; prescaler cleared; done=0. Load has priority over counting.
- Load clamp: seconds units >9 -> 9; tens >5 -> 5; minutes >9 -> 9.
- State after a load: IDLE if the loaded value is 0:00, else PAUSED.
- FSM states are IDLE, PAUSED, RUN. All outputs are registered.
- IDLE:
  - Count is 0:00; enablen ignored.
  - loadn=0 with a nonzero value -> PAUSED.
- PAUSED:
  - Count is nonzero; prescaler held at 0.
  - enablen=0 and loadn=1 -> RUN.
- RUN:
  - Prescaler increments each clk.
  - At TICK_DIV-1 it wraps to 0 and issues an internal tick.
  - enablen=1 -> PAUSED; prescaler clears, and a partial second is discarded.
- Tick (RUN only): decrement M:SS with BCD borrow.
  - sec_ones 0 -> 9 with a borrow into sec_tens.
  - sec_tens 0 -> 5 with a borrow into min_ones.
  - The value never underflows below 0:00.
- Reaching 0:00: on the tick that moves 0:01 -> 0:00, state -> IDLE and done=1 for exactly one clk.
- Timing: zero asserts on the same edge as done. running=1 iff state==RUN.
- Tick latency: the first decrement occurs TICK_DIV clks after the RUN entry edge.
- Simultaneous loadn=0 and tick: the load wins, no decrement, done=0.
- Simultaneous enablen 0->1 and tick: the tick is discarded and the state goes to PAUSED.
- Reset mid-count: everything returns to reset values immediately, with no done pulse.
- Maximum count 9:59; the countdown takes 599 ticks.

Optional Feature:
- Macro: COUNTDOWN_EXT_TICK_EN.
- Defined:
  - Adds input port tick_in (1 bit, one-clk pulse); the internal prescaler is removed.
  - A decrement occurs on a clk where state==RUN and tick_in=1.
  - RUN entry/exit does not clear any divider.
  - TICK_DIV and DIV_W are unused.
- Not defined: the internal prescaler is used as described above; no tick_in port.

Test Plan:
- Reset release, no load -> digits 0/0/0, zero=1, running=0; enablen=0 leaves the state in IDLE.
- TICK_DIV=4; load 1:05, enablen=0:
  - sec_ones reads 4 exactly 4 clks after RUN entry.
  - The sequence 1:05 -> 1:04 ... 1:00 -> 0:59 checks both borrows.
  - done pulses exactly once at 0:00, then zero=1 and running=0.
- Load 0:01, run -> done pulse after TICK_DIV clks; no underflow after 10 further ticks, display stays 0:00.
- Load digits 15/7/12 (min/tens/units) -> display clamps to 9:59.
- Mid-run pause:
  - Drive enablen=1 at prescaler=2 -> PAUSED, value held.
  - Re-enable -> the next decrement comes a full TICK_DIV clks later.
- Load 2:30 on the same clk as a tick -> display 2:30, no decrement.
- Assert clearn mid-run -> immediate 0:00, zero=1, no done pulse.
